// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline definitions: ALU-op encoding and the control-bundle types
// carried by the ID/EX, EX/MEM and MEM/WB pipeline registers.
package cpu_pipe_pkg;

    localparam int ALU_OP_W = 3;

    localparam logic [ALU_OP_W-1:0] ALU_ADD = 3'd0;
    localparam logic [ALU_OP_W-1:0] ALU_SUB = 3'd1;
    localparam logic [ALU_OP_W-1:0] ALU_AND = 3'd2;
    localparam logic [ALU_OP_W-1:0] ALU_OR  = 3'd3;
    localparam logic [ALU_OP_W-1:0] ALU_SLT = 3'd4;
    localparam logic [ALU_OP_W-1:0] ALU_NOR = 3'd5;
    localparam logic [ALU_OP_W-1:0] ALU_XOR = 3'd6;
    localparam logic [ALU_OP_W-1:0] ALU_SLL = 3'd7;

    typedef struct packed {
        logic                reg_dst;
        logic [ALU_OP_W-1:0] alu_op;
        logic                alu_src;
    } ex_ctrl_t;

    typedef struct packed {
        logic mem_read;
        logic mem_write;
    } mem_ctrl_t;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
    } wb_ctrl_t;

    typedef struct packed {
        ex_ctrl_t  ex;
        mem_ctrl_t mem;
        wb_ctrl_t  wb;
    } ctrl_t;

    // A bubble: no register write, no memory access.
    localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear, else step unless already at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with valid/ready stall handshake, flush-to-bubble,
// pre-resolved destination register and stall/bubble performance counters.
module id_ex_pipe_reg
    import cpu_pipe_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int REG_W    = 5,
    parameter int ALU_OP_W = 3,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    input  logic                cnt_clear,

    input  logic                in_valid,
    output logic                in_ready,
    input  logic                reg_dst_in,
    input  logic                alu_src_in,
    input  logic                mem_read_in,
    input  logic                mem_write_in,
    input  logic                reg_write_in,
    input  logic                mem_to_reg_in,
    input  logic [ALU_OP_W-1:0] alu_op_in,
    input  logic [DATA_W-1:0]   rs_data_in,
    input  logic [DATA_W-1:0]   rt_data_in,
    input  logic [DATA_W-1:0]   imm_in,
    input  logic [REG_W-1:0]    rs_in,
    input  logic [REG_W-1:0]    rt_in,
    input  logic [REG_W-1:0]    rd_in,

    output logic                out_valid,
    input  logic                out_ready,
    output logic                reg_dst,
    output logic                alu_src,
    output logic                mem_read,
    output logic                mem_write,
    output logic                reg_write,
    output logic                mem_to_reg,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic [DATA_W-1:0]   rs_data,
    output logic [DATA_W-1:0]   rt_data,
    output logic [DATA_W-1:0]   imm,
    output logic [REG_W-1:0]    rs,
    output logic [REG_W-1:0]    rt,
    output logic [REG_W-1:0]    rd,
    output logic [REG_W-1:0]    dest,

    output logic [CNT_W-1:0]    stall_cnt,
    output logic [CNT_W-1:0]    bubble_cnt
);

    logic                out_valid_q,  out_valid_d;
    logic                reg_dst_q,    reg_dst_d;
    logic                alu_src_q,    alu_src_d;
    logic [ALU_OP_W-1:0] alu_op_q,     alu_op_d;
    mem_ctrl_t           mem_q,        mem_d;
    wb_ctrl_t            wb_q,         wb_d;
    logic [DATA_W-1:0]   rs_data_q,    rs_data_d;
    logic [DATA_W-1:0]   rt_data_q,    rt_data_d;
    logic [DATA_W-1:0]   imm_q,        imm_d;
    logic [REG_W-1:0]    rs_q,         rs_d;
    logic [REG_W-1:0]    rt_q,         rt_d;
    logic [REG_W-1:0]    rd_q,         rd_d;
    logic [REG_W-1:0]    dest_q,       dest_d;

    logic load;
    logic bubble;
    logic stall_inc;
    logic bubble_inc;

    // Ready is independent of flush so decode never sees a flush-driven
    // combinational path back through this stage.
    assign in_ready = !out_valid_q || out_ready;
    assign load     = in_ready && in_valid;
    assign bubble   = in_ready && !in_valid;

    assign stall_inc  = out_valid_q && !out_ready && !flush;
    assign bubble_inc = flush || (bubble && out_valid_q);

    // Next-state for the pipeline fields: flush > load > bubble > hold.
    // Killing an instruction only clears control; data/address fields keep
    // their old values since nothing downstream uses them without valid.
    always_comb begin
        out_valid_d = out_valid_q;
        reg_dst_d   = reg_dst_q;
        alu_src_d   = alu_src_q;
        alu_op_d    = alu_op_q;
        mem_d       = mem_q;
        wb_d        = wb_q;
        rs_data_d   = rs_data_q;
        rt_data_d   = rt_data_q;
        imm_d       = imm_q;
        rs_d        = rs_q;
        rt_d        = rt_q;
        rd_d        = rd_q;
        dest_d      = dest_q;

        if (flush || bubble) begin
            out_valid_d = 1'b0;
            reg_dst_d   = CTRL_NOP.ex.reg_dst;
            alu_src_d   = CTRL_NOP.ex.alu_src;
            alu_op_d    = '0;
            mem_d       = CTRL_NOP.mem;
            wb_d        = CTRL_NOP.wb;
        end else if (load) begin
            out_valid_d    = 1'b1;
            reg_dst_d      = reg_dst_in;
            alu_src_d      = alu_src_in;
            alu_op_d       = alu_op_in;
            mem_d.mem_read = mem_read_in;
            mem_d.mem_write = mem_write_in;
            wb_d.reg_write  = reg_write_in;
            wb_d.mem_to_reg = mem_to_reg_in;
            rs_data_d      = rs_data_in;
            rt_data_d      = rt_data_in;
            imm_d          = imm_in;
            rs_d           = rs_in;
            rt_d           = rt_in;
            rd_d           = rd_in;
            dest_d         = reg_dst_in ? rd_in : rt_in;
        end
    end

    // Pipeline register bank.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            reg_dst_q   <= 1'b0;
            alu_src_q   <= 1'b0;
            alu_op_q    <= '0;
            mem_q       <= CTRL_NOP.mem;
            wb_q        <= CTRL_NOP.wb;
            rs_data_q   <= '0;
            rt_data_q   <= '0;
            imm_q       <= '0;
            rs_q        <= '0;
            rt_q        <= '0;
            rd_q        <= '0;
            dest_q      <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            reg_dst_q   <= reg_dst_d;
            alu_src_q   <= alu_src_d;
            alu_op_q    <= alu_op_d;
            mem_q       <= mem_d;
            wb_q        <= wb_d;
            rs_data_q   <= rs_data_d;
            rt_data_q   <= rt_data_d;
            imm_q       <= imm_d;
            rs_q        <= rs_d;
            rt_q        <= rt_d;
            rd_q        <= rd_d;
            dest_q      <= dest_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_inc),
        .clr   (cnt_clear),
        .cnt   (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (bubble_inc),
        .clr   (cnt_clear),
        .cnt   (bubble_cnt)
    );

    assign out_valid  = out_valid_q;
    assign reg_dst    = reg_dst_q;
    assign alu_src    = alu_src_q;
    assign alu_op     = alu_op_q;
    assign mem_read   = mem_q.mem_read;
    assign mem_write  = mem_q.mem_write;
    assign reg_write  = wb_q.reg_write;
    assign mem_to_reg = wb_q.mem_to_reg;
    assign rs_data    = rs_data_q;
    assign rt_data    = rt_data_q;
    assign imm        = imm_q;
    assign rs         = rs_q;
    assign rt         = rt_q;
    assign rd         = rd_q;
    assign dest       = dest_q;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Self-checking bench for id_ex_pipe_reg (small counters so saturation is
// reachable in a few cycles).
module tb_id_ex_pipe_reg;

    localparam int DATA_W   = 32;
    localparam int REG_W    = 5;
    localparam int ALU_OP_W = 3;
    localparam int CNT_W    = 2;

    typedef struct packed {
        logic                reg_dst;
        logic                alu_src;
        logic                mem_read;
        logic                mem_write;
        logic                reg_write;
        logic                mem_to_reg;
        logic [ALU_OP_W-1:0] alu_op;
        logic [DATA_W-1:0]   rs_data;
        logic [DATA_W-1:0]   rt_data;
        logic [DATA_W-1:0]   imm;
        logic [REG_W-1:0]    rs;
        logic [REG_W-1:0]    rt;
        logic [REG_W-1:0]    rd;
    } instr_t;

    logic clk = 1'b0;
    logic reset, flush, cnt_clear, in_valid, in_ready, out_valid, out_ready;
    logic reg_dst_in, alu_src_in, mem_read_in, mem_write_in, reg_write_in, mem_to_reg_in;
    logic [ALU_OP_W-1:0] alu_op_in;
    logic [DATA_W-1:0]   rs_data_in, rt_data_in, imm_in;
    logic [REG_W-1:0]    rs_in, rt_in, rd_in;
    logic reg_dst, alu_src, mem_read, mem_write, reg_write, mem_to_reg;
    logic [ALU_OP_W-1:0] alu_op;
    logic [DATA_W-1:0]   rs_data, rt_data, imm;
    logic [REG_W-1:0]    rs, rt, rd, dest;
    logic [CNT_W-1:0]    stall_cnt, bubble_cnt;

    int tests = 0;
    int fails = 0;
    instr_t exp_q[$];

    always #5 clk = ~clk;

    id_ex_pipe_reg #(
        .DATA_W(DATA_W), .REG_W(REG_W), .ALU_OP_W(ALU_OP_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .flush(flush), .cnt_clear(cnt_clear),
        .in_valid(in_valid), .in_ready(in_ready),
        .reg_dst_in(reg_dst_in), .alu_src_in(alu_src_in), .mem_read_in(mem_read_in),
        .mem_write_in(mem_write_in), .reg_write_in(reg_write_in), .mem_to_reg_in(mem_to_reg_in),
        .alu_op_in(alu_op_in), .rs_data_in(rs_data_in), .rt_data_in(rt_data_in), .imm_in(imm_in),
        .rs_in(rs_in), .rt_in(rt_in), .rd_in(rd_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .reg_dst(reg_dst), .alu_src(alu_src), .mem_read(mem_read), .mem_write(mem_write),
        .reg_write(reg_write), .mem_to_reg(mem_to_reg), .alu_op(alu_op),
        .rs_data(rs_data), .rt_data(rt_data), .imm(imm), .rs(rs), .rt(rt), .rd(rd),
        .dest(dest), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
    );

    function automatic instr_t rand_instr();
        instr_t t;
        t.reg_dst    = 1'($urandom);
        t.alu_src    = 1'($urandom);
        t.mem_read   = 1'($urandom);
        t.mem_write  = 1'($urandom);
        t.reg_write  = 1'($urandom);
        t.mem_to_reg = 1'($urandom);
        t.alu_op     = 3'($urandom);
        t.rs_data    = $urandom;
        t.rt_data    = $urandom;
        t.imm        = $urandom;
        t.rs         = 5'($urandom);
        t.rt         = 5'($urandom);
        t.rd         = 5'($urandom);
        return t;
    endfunction

    function automatic instr_t get_out();
        instr_t t;
        t = '{reg_dst, alu_src, mem_read, mem_write, reg_write, mem_to_reg,
              alu_op, rs_data, rt_data, imm, rs, rt, rd};
        return t;
    endfunction

    function automatic logic [REG_W-1:0] exp_dest(input instr_t t);
        return t.reg_dst ? t.rd : t.rt;
    endfunction

    task automatic drive(input instr_t t, input logic v);
        in_valid      = v;
        reg_dst_in    = t.reg_dst;
        alu_src_in    = t.alu_src;
        mem_read_in   = t.mem_read;
        mem_write_in  = t.mem_write;
        reg_write_in  = t.reg_write;
        mem_to_reg_in = t.mem_to_reg;
        alu_op_in     = t.alu_op;
        rs_data_in    = t.rs_data;
        rt_data_in    = t.rt_data;
        imm_in        = t.imm;
        rs_in         = t.rs;
        rt_in         = t.rt;
        rd_in         = t.rd;
    endtask

    // Advance one active edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_cnt();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cnt_clear = 1'b1;
        step();
        cnt_clear = 1'b0;
    endtask

    // Whenever nothing valid is held, no side-effecting control may be set.
    always @(negedge clk) begin
        if (!reset) begin
            tests++;
            if (!out_valid && (reg_write || mem_read || mem_write || mem_to_reg) !== 1'b0) begin
                fails++;
                $display("FAIL invariant t=%0t rw=%b mr=%b mw=%b m2r=%b want all 0",
                         $time, reg_write, mem_read, mem_write, mem_to_reg);
            end
        end
    end

    task automatic test_reset();
        instr_t a;
        tests++;
        if ({out_valid, get_out(), dest, stall_cnt, bubble_cnt} !== '0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_initial valid=%b dest=%0d in_ready=%b want all 0, in_ready 1",
                     out_valid, dest, in_ready);
        end
        @(negedge clk);
        reset = 1'b0;
        a = rand_instr();
        drive(a, 1'b1);
        step();
        out_ready = 1'b0;
        step();
        step();
        tests++;
        if (stall_cnt !== 2'd2 || out_valid !== 1'b1) begin
            fails++;
            $display("FAIL reset_prestall stall_cnt=%0d valid=%b want 2 1", stall_cnt, out_valid);
        end
        #2 reset = 1'b1;
        #1;
        tests++;
        if ({out_valid, get_out(), dest} !== '0) begin
            fails++;
            $display("FAIL reset_outputs valid=%b out=%h dest=%0d want 0", out_valid, get_out(), dest);
        end
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_in_ready got %b want 1", in_ready);
        end
        tests++;
        if (stall_cnt !== '0 || bubble_cnt !== '0) begin
            fails++;
            $display("FAIL reset_counters stall=%0d bubble=%0d want 0 0", stall_cnt, bubble_cnt);
        end
        step();
        @(negedge clk);
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_no_replay out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_stream();
        instr_t t, e;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            t = rand_instr();
            if (k == 0) begin t.reg_dst = 1'b1; t.rd = 5'd7; t.rt = 5'd3; end
            if (k == 1) begin t.reg_dst = 1'b0; t.rd = 5'd7; t.rt = 5'd3; end
            drive(t, 1'b1);
            exp_q.push_back(t);
            step();
            tests++;
            if (out_valid !== 1'b1) begin
                fails++;
                $display("FAIL stream_valid k=%0d got %b want 1", k, out_valid);
            end else begin
                e = exp_q.pop_front();
                tests++;
                if (get_out() !== e) begin
                    fails++;
                    $display("FAIL stream_data k=%0d got %h want %h", k, get_out(), e);
                end
                tests++;
                if (dest !== exp_dest(e)) begin
                    fails++;
                    $display("FAIL stream_dest k=%0d got %0d want %0d", k, dest, exp_dest(e));
                end
            end
        end
        in_valid = 1'b0;
        step();
        tests++;
        if (out_valid !== 1'b0 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL stream_drain valid=%b left=%0d want 0 0", out_valid, exp_q.size());
        end
    endtask

    task automatic test_stall();
        instr_t a, b;
        clear_cnt();
        a = rand_instr();
        b = rand_instr();
        drive(a, 1'b1);
        step();
        drive(b, 1'b1);
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            tests++;
            if (in_ready !== 1'b0) begin
                fails++;
                $display("FAIL stall_in_ready k=%0d got %b want 0", k, in_ready);
            end
            step();
            tests++;
            if (get_out() !== a || out_valid !== 1'b1 || dest !== exp_dest(a)) begin
                fails++;
                $display("FAIL stall_frozen k=%0d got %h want %h", k, get_out(), a);
            end
        end
        tests++;
        if (stall_cnt !== 2'd3) begin
            fails++;
            $display("FAIL stall_cnt got %0d want 3", stall_cnt);
        end
        out_ready = 1'b1;
        step();
        tests++;
        if (get_out() !== b || out_valid !== 1'b1) begin
            fails++;
            $display("FAIL stall_release got %h want %h", get_out(), b);
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_flush();
        instr_t f, g;
        clear_cnt();
        f = rand_instr();
        f.reg_write = 1'b1;
        f.mem_write = 1'b1;
        g = rand_instr();
        drive(f, 1'b1);
        step();
        drive(g, 1'b1);
        out_ready = 1'b0;
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        tests++;
        if (out_valid !== 1'b0 || reg_write !== 1'b0 || mem_write !== 1'b0) begin
            fails++;
            $display("FAIL flush_stall_ctrl valid=%b rw=%b mw=%b want 0 0 0", out_valid, reg_write, mem_write);
        end
        tests++;
        if (rs_data !== f.rs_data || dest !== exp_dest(f)) begin
            fails++;
            $display("FAIL flush_stall_data rs_data=%h dest=%0d want %h %0d",
                     rs_data, dest, f.rs_data, exp_dest(f));
        end
        tests++;
        if (bubble_cnt !== 2'd1 || stall_cnt !== 2'd1) begin
            fails++;
            $display("FAIL flush_stall_cnt bubble=%0d stall=%0d want 1 1", bubble_cnt, stall_cnt);
        end
        out_ready = 1'b1;
        drive(g, 1'b1);
        flush = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        tests++;
        if (out_valid !== 1'b0 || rs_data !== f.rs_data || bubble_cnt !== 2'd2) begin
            fails++;
            $display("FAIL flush_drop_input valid=%b rs_data=%h bubble=%0d want 0 %h 2",
                     out_valid, rs_data, bubble_cnt, f.rs_data);
        end
    endtask

    task automatic test_bubble();
        instr_t a, b;
        clear_cnt();
        a = rand_instr();
        b = rand_instr();
        drive(a, 1'b1);
        step();
        in_valid = 1'b0;
        step();
        tests++;
        if (out_valid !== 1'b0 || {reg_dst, alu_src, mem_read, mem_write, reg_write, mem_to_reg, alu_op} !== '0) begin
            fails++;
            $display("FAIL bubble_ctrl valid=%b alu_op=%0d rd=%b as=%b want all 0", out_valid, alu_op, reg_dst, alu_src);
        end
        tests++;
        if (rs_data !== a.rs_data || rt_data !== a.rt_data || imm !== a.imm) begin
            fails++;
            $display("FAIL bubble_data_hold rs=%h rt=%h imm=%h want %h %h %h",
                     rs_data, rt_data, imm, a.rs_data, a.rt_data, a.imm);
        end
        tests++;
        if (bubble_cnt !== 2'd1) begin
            fails++;
            $display("FAIL bubble_cnt got %0d want 1", bubble_cnt);
        end
        step();
        tests++;
        if (bubble_cnt !== 2'd1) begin
            fails++;
            $display("FAIL bubble_idle_cnt got %0d want 1", bubble_cnt);
        end
        drive(b, 1'b1);
        step();
        in_valid = 1'b0;
        tests++;
        if (get_out() !== b || out_valid !== 1'b1 || dest !== exp_dest(b)) begin
            fails++;
            $display("FAIL bubble_reload got %h want %h", get_out(), b);
        end
    endtask

    task automatic test_saturation();
        instr_t a;
        clear_cnt();
        a = rand_instr();
        drive(a, 1'b1);
        step();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) step();
        tests++;
        if (stall_cnt !== 2'd3) begin
            fails++;
            $display("FAIL sat_stall_cnt got %0d want 3", stall_cnt);
        end
        cnt_clear = 1'b1;
        step();
        cnt_clear = 1'b0;
        tests++;
        if (stall_cnt !== 2'd0) begin
            fails++;
            $display("FAIL sat_clear got %0d want 0", stall_cnt);
        end
        step();
        tests++;
        if (stall_cnt !== 2'd1) begin
            fails++;
            $display("FAIL sat_restart got %0d want 1", stall_cnt);
        end
        cnt_clear = 1'b1;
        step();
        cnt_clear = 1'b0;
        tests++;
        if (stall_cnt !== 2'd0) begin
            fails++;
            $display("FAIL sat_clear_vs_inc got %0d want 0", stall_cnt);
        end
        tests++;
        if (get_out() !== a || out_valid !== 1'b1) begin
            fails++;
            $display("FAIL sat_clear_pipeline got %h want %h", get_out(), a);
        end
        out_ready = 1'b1;
        step();
    endtask

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        cnt_clear = 1'b0;
        out_ready = 1'b1;
        drive('0, 1'b0);
        #12;
        test_reset();
        test_stream();
        test_stall();
        test_flush();
        test_bubble();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

endmodule
